wash_cycle_ctrl: RTL and testbench

- Parametrised second-generation washing machine controller.
- Runs the full programme sequence: fill, detergent, wash, then 0..N rinses, each rinse being a fill, agitate and drain. A final spin follows.
- Internal phase timers replace the external timeout inputs. Adds pause, door-open and fill/drain watchdog faults.
- Sits between the front-panel/sensor inputs and the valve, motor and lock actuator drivers.

---
 rtl/wash_cycle_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_wash_cycle_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wash_cycle_ctrl.sv
// Washing machine programme controller: fill, detergent, wash, N rinses, spin, with
// internal phase timers, pause and fault handling. Optional soak phase under `WASH_SOAK_EN.
module wash_cycle_ctrl #(
    parameter int TIMER_W     = 16,
    parameter int WASH_TICKS  = 1000,
    parameter int RINSE_TICKS = 500,
    parameter int SPIN_TICKS  = 800,
    parameter int FILL_TMO    = 2000,
    parameter int DRAIN_TMO   = 2000,
    parameter int SOAK_TICKS  = 300,
    parameter int RINSE_W     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               door_closed,
    input  logic               water_full,
    input  logic               water_empty,
    input  logic               detergent_added,
    input  logic               pause,
    input  logic [RINSE_W-1:0] rinse_count,
    output logic               door_lock,
    output logic               fill_valve,
    output logic               drain_valve,
    output logic               motor_on,
    output logic               motor_fast,
    output logic               detergent_req,
    output logic               done,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [3:0]         state_o,
    output logic [RINSE_W-1:0] rinse_left
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FILL      = 4'd1;
    localparam logic [3:0] S_DETERGENT = 4'd2;
    localparam logic [3:0] S_AGITATE   = 4'd3;
    localparam logic [3:0] S_DRAIN     = 4'd4;
    localparam logic [3:0] S_SPIN      = 4'd5;
    localparam logic [3:0] S_DONE      = 4'd6;
    localparam logic [3:0] S_FAULT     = 4'd7;
    localparam logic [3:0] S_SOAK      = 4'd8;

    localparam logic PH_WASH  = 1'b0;
    localparam logic PH_RINSE = 1'b1;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_FILL  = 2'd1;
    localparam logic [1:0] FC_DRAIN = 2'd2;
    localparam logic [1:0] FC_DOOR  = 2'd3;

    localparam logic [TIMER_W-1:0] WASH_LAST  = TIMER_W'(WASH_TICKS - 1);
    localparam logic [TIMER_W-1:0] RINSE_LAST = TIMER_W'(RINSE_TICKS - 1);
    localparam logic [TIMER_W-1:0] SPIN_LAST  = TIMER_W'(SPIN_TICKS - 1);
    localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TMO - 1);
    localparam logic [TIMER_W-1:0] DRAIN_LAST = TIMER_W'(DRAIN_TMO - 1);
`ifdef WASH_SOAK_EN
    localparam logic [TIMER_W-1:0] SOAK_LAST  = TIMER_W'(SOAK_TICKS - 1);
`endif

    logic [3:0]         state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic               phase_reg, phase_next;
    logic [RINSE_W-1:0] rinse_reg, rinse_next;
    logic [1:0]         fault_code_reg, fault_code_next;

    logic locked;
    logic timed;
    logic paused;
    logic agitate_last;

    always_comb begin
        locked = (state_reg == S_FILL) || (state_reg == S_DETERGENT) ||
                 (state_reg == S_AGITATE) || (state_reg == S_DRAIN) ||
                 (state_reg == S_SPIN) || (state_reg == S_SOAK);
        timed  = (state_reg == S_FILL) || (state_reg == S_AGITATE) ||
                 (state_reg == S_DRAIN) || (state_reg == S_SPIN) ||
                 (state_reg == S_SOAK);
    end

    assign paused       = pause && locked;
    assign agitate_last = (phase_reg == PH_RINSE) ? (timer_reg == RINSE_LAST)
                                                  : (timer_reg == WASH_LAST);

    // Door fault beats pause, which beats every sensor or timer driven exit.
    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        rinse_next      = rinse_reg;
        fault_code_next = fault_code_reg;
        if (locked && !door_closed) begin
            state_next      = S_FAULT;
            fault_code_next = FC_DOOR;
        end else if (!paused) begin
            case (state_reg)
                S_IDLE: begin
                    if (start && door_closed) begin
                        state_next = S_FILL;
                        rinse_next = rinse_count;
                        phase_next = PH_WASH;
                    end
                end
                S_FILL: begin
                    if (water_full) begin
                        state_next = (phase_reg == PH_WASH) ? S_DETERGENT : S_AGITATE;
                    end else if (timer_reg == FILL_LAST) begin
                        state_next      = S_FAULT;
                        fault_code_next = FC_FILL;
                    end
                end
                S_DETERGENT: begin
                    if (detergent_added) begin
`ifdef WASH_SOAK_EN
                        state_next = (phase_reg == PH_WASH) ? S_SOAK : S_AGITATE;
`else
                        state_next = S_AGITATE;
`endif
                    end
                end
                S_AGITATE: begin
                    if (agitate_last) begin
                        state_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (water_empty) begin
                        if (rinse_reg != '0) begin
                            rinse_next = rinse_reg - 1'b1;
                            phase_next = PH_RINSE;
                            state_next = S_FILL;
                        end else begin
                            state_next = S_SPIN;
                        end
                    end else if (timer_reg == DRAIN_LAST) begin
                        state_next      = S_FAULT;
                        fault_code_next = FC_DRAIN;
                    end
                end
                S_SPIN: begin
                    if (timer_reg == SPIN_LAST) begin
                        state_next = S_DONE;
                    end
                end
`ifdef WASH_SOAK_EN
                S_SOAK: begin
                    if (timer_reg == SOAK_LAST) begin
                        state_next = S_AGITATE;
                    end
                end
`endif
                S_DONE:  state_next = S_IDLE;
                S_FAULT: state_next = S_FAULT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        timer_next = timer_reg;
        if (state_next != state_reg) begin
            timer_next = '0;
        end else if (timed && !paused) begin
            timer_next = timer_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            timer_reg      <= '0;
            phase_reg      <= PH_WASH;
            rinse_reg      <= '0;
            fault_code_reg <= FC_NONE;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            phase_reg      <= phase_next;
            rinse_reg      <= rinse_next;
            fault_code_reg <= fault_code_next;
        end
    end

    // Actuator order: fill, drain, motor, fast, detergent; all are gated off while paused.
    logic [4:0] act_raw;
    logic [4:0] act_out;

    always_comb begin
        act_raw = 5'b00000;
        case (state_reg)
            S_FILL:      act_raw = 5'b10000;
            S_DETERGENT: act_raw = 5'b00001;
            S_AGITATE:   act_raw = 5'b00100;
            S_DRAIN:     act_raw = 5'b01000;
            S_SPIN:      act_raw = 5'b01110;
            default:     act_raw = 5'b00000;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_act_gate
            assign act_out[gi] = act_raw[gi] && !paused;
        end
    endgenerate

    assign fill_valve    = act_out[4];
    assign drain_valve   = act_out[3];
    assign motor_on      = act_out[2];
    assign motor_fast    = act_out[1];
    assign detergent_req = act_out[0];

    // In FAULT the door stays locked until the tub has drained.
    assign door_lock  = locked || ((state_reg == S_FAULT) && !water_empty);
    assign done       = (state_reg == S_DONE);
    assign fault      = (state_reg == S_FAULT);
    assign fault_code = fault_code_reg;
    assign state_o    = state_reg;
    assign rinse_left = rinse_reg;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl with short phase timers; covers `WASH_SOAK_EN builds.
module tb_wash_cycle_ctrl;

    localparam int SOAK_T = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       door_closed = 1'b1;
    logic       water_full = 1'b0;
    logic       water_empty = 1'b0;
    logic       detergent_added = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] rinse_count = 2'd0;
    logic       door_lock, fill_valve, drain_valve, motor_on, motor_fast;
    logic       detergent_req, done, fault;
    logic [1:0] fault_code;
    logic [3:0] state_o;
    logic [1:0] rinse_left;

    int vectors = 0;
    int miscompares = 0;
    int n;

    wash_cycle_ctrl #(
        .TIMER_W(16), .WASH_TICKS(8), .RINSE_TICKS(4), .SPIN_TICKS(6),
        .FILL_TMO(16), .DRAIN_TMO(16), .SOAK_TICKS(SOAK_T), .RINSE_W(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .door_closed(door_closed),
        .water_full(water_full), .water_empty(water_empty),
        .detergent_added(detergent_added), .pause(pause), .rinse_count(rinse_count),
        .door_lock(door_lock), .fill_valve(fill_valve), .drain_valve(drain_valve),
        .motor_on(motor_on), .motor_fast(motor_fast), .detergent_req(detergent_req),
        .done(done), .fault(fault), .fault_code(fault_code), .state_o(state_o),
        .rinse_left(rinse_left)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles spent in the given state, bounded so a stuck DUT cannot hang the run.
    task automatic dwell(input logic [3:0] code, output int cnt);
        cnt = 0;
        while (state_o == code && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; door_closed = 1'b1; water_full = 1'b0; water_empty = 1'b0;
        detergent_added = 1'b0; pause = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_prog(input logic [1:0] rc);
        rinse_count = rc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start->FILL", state_o, 1);
    endtask

    // Water_full after `wait_cyc` further fill cycles; wash phase goes via DETERGENT.
    task automatic fill_wash(input int wait_cyc);
        repeat (wait_cyc) tick();
        water_full = 1'b1;
        tick();
        water_full = 1'b0;
        check("FILL->DETERGENT", state_o, 2);
        check("detergent_req", detergent_req, 1);
        repeat (2) tick();
        detergent_added = 1'b1;
        tick();
        detergent_added = 1'b0;
`ifdef WASH_SOAK_EN
        check("DETERGENT->SOAK", state_o, 8);
        check("soak door_lock", door_lock, 1);
        dwell(4'd8, n);
        check("soak dwell", n, SOAK_T);
`endif
        check("enter AGITATE", state_o, 3);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst state", state_o, 0);
        check("rst outputs", {door_lock, fill_valve, drain_valve, motor_on, motor_fast,
                              detergent_req, done, fault}, 0);
        check("rst fault_code", fault_code, 0);
        check("rst rinse_left", rinse_left, 0);

        // Normal run, one rinse, sensors answer on the third cycle
        start_prog(2'd1);
        check("fill_valve", fill_valve, 1);
        check("door_lock fill", door_lock, 1);
        check("rinse_left loaded", rinse_left, 1);
        fill_wash(2);
        check("motor_on agitate", motor_on, 1);
        dwell(4'd3, n);
        check("wash agitate dwell", n, 8);
        check("->DRAIN", state_o, 4);
        check("drain_valve", drain_valve, 1);
        repeat (2) tick();
        water_empty = 1'b1;
        tick();
        water_empty = 1'b0;
        check("DRAIN->FILL rinse", state_o, 1);
        check("rinse_left dec", rinse_left, 0);
        repeat (2) tick();
        water_full = 1'b1;
        tick();
        water_full = 1'b0;
        check("rinse FILL->AGITATE", state_o, 3);
        dwell(4'd3, n);
        check("rinse agitate dwell", n, 4);
        check("rinse ->DRAIN", state_o, 4);
        repeat (2) tick();
        water_empty = 1'b1;
        tick();
        check("DRAIN->SPIN", state_o, 5);
        check("spin actuators", {motor_on, motor_fast, drain_valve}, 3'b111);
        start = 1'b1;
        dwell(4'd5, n);
        start = 1'b0;
        check("spin dwell with start", n, 6);
        check("->DONE", state_o, 6);
        check("done pulse", done, 1);
        check("door_lock done", door_lock, 0);
        tick();
        check("DONE->IDLE", state_o, 0);
        check("done cleared", done, 0);
        check("door_lock idle", door_lock, 0);
        water_empty = 1'b0;

        // Fill timeout
        do_reset();
        start_prog(2'd0);
        dwell(4'd1, n);
        check("fill tmo dwell", n, 16);
        check("fill tmo state", state_o, 7);
        check("fill tmo code", fault_code, 1);
        check("fill tmo fault", fault, 1);
        check("fill tmo valve", fill_valve, 0);
        check("fault lock full", door_lock, 1);
        repeat (5) tick();
        check("fault held", state_o, 7);
        water_empty = 1'b1;
        #1;
        check("fault lock empty", door_lock, 0);

        // Door opened during agitate
        do_reset();
        start_prog(2'd0);
        fill_wash(0);
        repeat (4) tick();
        door_closed = 1'b0;
        tick();
        check("door fault state", state_o, 7);
        check("door fault code", fault_code, 3);
        check("door fault motor", motor_on, 0);

        // Pause after three unpaused agitate cycles
        do_reset();
        start_prog(2'd0);
        fill_wash(0);
        repeat (3) tick();
        pause = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("pause motor_on", motor_on, 0);
            check("pause state", state_o, 3);
            tick();
        end
        check("pause door_lock", door_lock, 1);
        pause = 1'b0;
        #1;
        dwell(4'd3, n);
        check("post-pause dwell", n, 5);
        check("post-pause DRAIN", state_o, 4);

        // Drain timeout tie: water_empty on the last watchdog cycle wins
        tick();
        repeat (14) tick();
        check("drain tie pre", state_o, 4);
        water_empty = 1'b1;
        tick();
        check("drain tie ->SPIN", state_o, 5);
        check("drain tie no fault", fault, 0);

        // Reset mid-spin
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid-spin reset state", state_o, 0);
        check("mid-spin reset outputs", {door_lock, fill_valve, drain_valve, motor_on,
                                         motor_fast, detergent_req, done, fault}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
